// File: rtl/hls_loader_pkg.sv
// Shared types and helpers for the Bambu slave-memory loader.
// Defines the loader state enum, the default word width and the channel-0 strobe packer.
package hls_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WR_WAIT,
        ST_START,
        ST_RUN,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_DONE
    } loader_state_t;

    localparam int LOADER_WORD_W = 32;

    // Channel 1 of the slave port is never used; only channel 0 carries requests.
    function automatic logic [1:0] ch0_strobe(input logic en);
        return {1'b0, en};
    endfunction

endpackage

// File: rtl/hls_slave_req_port.sv
// Single-outstanding slave request register: holds oe/we/addr/data until DataRdy,
// then drops the strobe and keeps the captured read word.
module hls_slave_req_port
    import hls_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int WORD_W = LOADER_WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue,
    input  logic              is_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_data,
    input  logic              data_rdy,
    input  logic [DATA_W-1:0] rdata,
    output logic              oe,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] wdata,
    output logic              ack,
    output logic [WORD_W-1:0] rd_word
);

    logic pending;

    // DataRdy only counts while a request is outstanding.
    assign ack = pending & data_rdy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            oe      <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            rd_word <= '0;
        end else if (pending) begin
            if (data_rdy) begin
                pending <= 1'b0;
                oe      <= 1'b0;
                we      <= 1'b0;
                if (oe)
                    rd_word <= rdata[WORD_W-1:0];
            end
        end else if (issue) begin
            pending <= 1'b1;
            we      <= is_write;
            oe      <= ~is_write;
            addr    <= req_addr;
            wdata   <= req_data;
        end
    end

    logic unused_rdata;
    assign unused_rdata = &{1'b0, rdata[DATA_W-1:WORD_W]};

endmodule

// File: rtl/hls_slave_mem_loader.sv
// Host-side loader for a Bambu accelerator slave port: writes words, pulses start, times the run.
// Define LOADER_READBACK_EN to also read RD_WORDS result words back and stream them on rsp_*.
module hls_slave_mem_loader
    import hls_loader_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 64,
    parameter int SIZE_W   = 7,
    parameter int WORD_W   = LOADER_WORD_W,
    parameter int RD_WORDS = 24,
    parameter int RD_BASE  = 0,
    parameter int TIMEOUT  = 200000000,
    parameter int CNT_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [WORD_W-1:0]   cmd_data,
    input  logic                cmd_last,
    output logic [1:0]          S_oe_ram,
    output logic [1:0]          S_we_ram,
    output logic [2*ADDR_W-1:0] S_addr_ram,
    output logic [2*DATA_W-1:0] S_Wdata_ram,
    output logic [2*SIZE_W-1:0] S_data_ram_size,
    input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]          Sout_DataRdy,
    output logic                start_port,
    input  logic                done_port,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_W-1:0]   rsp_data,
    output logic                busy,
    output logic [CNT_W-1:0]    run_cycles,
    output logic                timeout
);

    localparam logic [SIZE_W-1:0] SIZE_BITS = SIZE_W'(WORD_W);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    loader_state_t     state;
    logic              last_r;
    logic              cmd_fire;
    logic              issue;
    logic [ADDR_W-1:0] req_addr;
    logic              oe0, we0, ack;
    logic [ADDR_W-1:0] addr0;
    logic [WORD_W-1:0] wdata0, rd_word;

    assign cmd_fire = cmd_valid & cmd_ready;

`ifdef LOADER_READBACK_EN
    localparam int IDX_W = $clog2(RD_WORDS + 1);
    logic [IDX_W-1:0]  idx;
    logic              rsp_valid_r;
    logic [ADDR_W-1:0] rd_addr;

    assign rd_addr  = ADDR_W'(RD_BASE + 4 * int'(idx));
    assign issue    = cmd_fire | (state == ST_RD_REQ);
    assign req_addr = cmd_fire ? cmd_addr : rd_addr;
`else
    assign issue    = cmd_fire;
    assign req_addr = cmd_addr;
`endif

    hls_slave_req_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_req_port (
        .clock    (clock),
        .reset    (reset),
        .issue    (issue),
        .is_write (cmd_fire),
        .req_addr (req_addr),
        .req_data (cmd_data),
        .data_rdy (Sout_DataRdy[0]),
        .rdata    (Sout_Rdata_ram[DATA_W-1:0]),
        .oe       (oe0),
        .we       (we0),
        .addr     (addr0),
        .wdata    (wdata0),
        .ack      (ack),
        .rd_word  (rd_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b0;
            last_r     <= 1'b0;
            start_port <= 1'b0;
            busy       <= 1'b0;
            run_cycles <= '0;
            timeout    <= 1'b0;
`ifdef LOADER_READBACK_EN
            idx         <= '0;
            rsp_valid_r <= 1'b0;
`endif
        end else begin
            start_port <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (cmd_fire) begin
                        last_r    <= cmd_last;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_WR_WAIT;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (ack) begin
                        if (last_r) begin
                            start_port <= 1'b1;
                            run_cycles <= CNT_W'(1);
                            state      <= ST_START;
                        end else begin
                            cmd_ready <= 1'b1;
                            state     <= ST_LOAD;
                        end
                    end
                end
                // START and RUN share the counting rule; done in the START cycle leaves run_cycles=1.
                ST_START, ST_RUN: begin
                    if (done_port) begin
`ifdef LOADER_READBACK_EN
                        idx   <= '0;
                        state <= ST_RD_REQ;
`else
                        busy  <= 1'b0;
                        state <= ST_DONE;
`endif
                    end else if (run_cycles >= CNT_W'(TIMEOUT)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        run_cycles <= sat_inc(run_cycles);
                        state      <= ST_RUN;
                    end
                end
`ifdef LOADER_READBACK_EN
                ST_RD_REQ: state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (ack) begin
                        rsp_valid_r <= 1'b1;
                        state       <= ST_RD_OUT;
                    end
                end
                ST_RD_OUT: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (idx == IDX_W'(RD_WORDS - 1)) begin
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_RD_REQ;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    if (cmd_valid)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign S_we_ram        = ch0_strobe(we0);
    assign S_addr_ram      = {{ADDR_W{1'b0}}, addr0};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, DATA_W'(wdata0)};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, (we0 | oe0) ? SIZE_BITS : {SIZE_W{1'b0}}};

`ifdef LOADER_READBACK_EN
    assign S_oe_ram  = ch0_strobe(oe0);
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rd_word;
    logic unused_bits;
    assign unused_bits = &{1'b0, Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};
`else
    assign S_oe_ram  = 2'b00;
    assign rsp_valid = 1'b0;
    assign rsp_data  = '0;
    logic unused_bits;
    assign unused_bits = &{1'b0, Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1],
                           rd_word, rsp_ready};
`endif

endmodule

// File: tb/tb_hls_slave_mem_loader.sv
// Self-checking bench for hls_slave_mem_loader: behavioural slave memory, randomized vectors,
// reference memory image and run-length model. Readback checks follow LOADER_READBACK_EN.
module tb_hls_slave_mem_loader;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 64;
    localparam int SIZE_W   = 7;
    localparam int WORD_W   = 32;
    localparam int RD_WORDS = 24;
    localparam int RD_BASE  = 0;
    localparam int TMO      = 150;
    localparam int CNT_W    = 32;
`ifdef LOADER_READBACK_EN
    localparam int EXP_RD = RD_WORDS;
`else
    localparam int EXP_RD = 0;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0, cmd_last = 1'b0;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic [WORD_W-1:0]   cmd_data = '0;
    logic [1:0]          S_oe_ram, S_we_ram, Sout_DataRdy;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [2*DATA_W-1:0] S_Wdata_ram, Sout_Rdata_ram;
    logic [2*SIZE_W-1:0] S_data_ram_size;
    logic                start_port, done_port = 1'b0;
    logic                rsp_valid, rsp_ready = 1'b0;
    logic [WORD_W-1:0]   rsp_data;
    logic                busy, timeout;
    logic [CNT_W-1:0]    run_cycles;

    hls_slave_mem_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .WORD_W(WORD_W),
        .RD_WORDS(RD_WORDS), .RD_BASE(RD_BASE), .TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_last(cmd_last),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .start_port(start_port), .done_port(done_port),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .run_cycles(run_cycles), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural slave memory: word array, ack after a programmable number of request cycles.
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    int          wdelay = 1, rdelay = 1, acc_cnt;
    logic        stray_rdy = 1'b0;
    logic        req0;
    int          cur_delay;

    assign req0      = S_we_ram[0] | S_oe_ram[0];
    assign cur_delay = S_we_ram[0] ? wdelay : rdelay;
    assign Sout_DataRdy   = {1'b0, (req0 && acc_cnt >= cur_delay) | stray_rdy};
    assign Sout_Rdata_ram = {{DATA_W{1'b1}}, 32'hDEADBEEF,
                             S_oe_ram[0] ? mem[S_addr_ram[9:2]] : 32'h0};

    always @(posedge clock or negedge reset) begin
        if (!reset) acc_cnt <= 0;
        else if (req0 && Sout_DataRdy[0]) begin
            if (S_we_ram[0]) mem[S_addr_ram[9:2]] <= S_Wdata_ram[31:0];
            acc_cnt <= 0;
        end else if (req0) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // Protocol monitor, sampled just after the falling edge.
    int we_pulses, oe_pulses, start_pulses, start_wide, both_err, hold_err, rsp_hold_err;
    int rv_count, ch1_err, size_err;
    logic prev_we = 0, prev_oe = 0, prev_start = 0, prev_rv = 0, prev_rready = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0] prev_wdata, prev_rdata;

    task automatic clear_mon();
        we_pulses = 0; oe_pulses = 0; start_pulses = 0; start_wide = 0; both_err = 0;
        hold_err = 0; rsp_hold_err = 0; rv_count = 0; ch1_err = 0; size_err = 0;
    endtask

    always begin
        @(negedge clock);
        #1;
        if (reset) begin
            if (S_we_ram[0] && !prev_we) we_pulses++;
            if (S_oe_ram[0] && !prev_oe) oe_pulses++;
            if (start_port && !prev_start) start_pulses++;
            if (start_port && prev_start) start_wide++;
            if (S_we_ram[0] && S_oe_ram[0]) both_err++;
            if (prev_we && S_we_ram[0] &&
                (S_addr_ram[9:0] != prev_addr || S_Wdata_ram[31:0] != prev_wdata)) hold_err++;
            if (prev_oe && S_oe_ram[0] && S_addr_ram[9:0] != prev_addr) hold_err++;
            if (prev_rv && !prev_rready && (!rsp_valid || rsp_data != prev_rdata)) rsp_hold_err++;
            if (rsp_valid && !prev_rv) rv_count++;
            if (S_we_ram[1] || S_oe_ram[1] || S_addr_ram[19:10] != 0 ||
                S_data_ram_size[13:7] != 0 || S_Wdata_ram[127:32] != 0) ch1_err++;
            if (req0 && S_data_ram_size[6:0] != 7'd32) size_err++;
        end
        prev_we = S_we_ram[0]; prev_oe = S_oe_ram[0]; prev_start = start_port;
        prev_rv = rsp_valid; prev_rready = rsp_ready; prev_rdata = rsp_data;
        prev_addr = S_addr_ram[9:0]; prev_wdata = S_Wdata_ram[31:0];
    end

    task automatic send_cmd(input logic [9:0] a, input logic [31:0] d, input logic last);
        int n = 0;
        cmd_addr = a; cmd_data = d; cmd_last = last; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        ref_mem[a[9:2]] = d;
    endtask

    logic [9:0]  q_a[$];
    logic [31:0] q_d[$];

    task automatic run_vector(input int d, input bit expect_to);
        int n = 0;
        int k = 0;
        clear_mon();
        foreach (q_a[i]) send_cmd(q_a[i], q_d[i], i == q_a.size() - 1);
        while (!start_port && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("start_seen", start_port, 1);
        if (!start_port) return;
        chk("busy_run", busy, 1);
        if (expect_to) begin
            while (!timeout && k < TMO + 20) begin
                @(negedge clock);
                k++;
            end
            chk("timeout_cycle", k, TMO);
            chk("timeout_runcyc", run_cycles, TMO);
        end else begin
            if (d == 0) done_port = 1'b1;
            for (int j = 0; j < d; j++) begin
                @(negedge clock);
                if (j == 0 && d >= 2) cmd_valid = 1'b1;
                if (j == 1) begin
                    chk("cmd_ready_in_run", cmd_ready, 0);
                    cmd_valid = 1'b0;
                end
            end
            done_port = 1'b1;
            @(negedge clock);
            done_port = 1'b0;
`ifdef LOADER_READBACK_EN
            for (int i = 0; i < RD_WORDS; i++) begin
                int w = 0;
                int stall = $urandom_range(0, 3);
                while (!rsp_valid && w < 60) begin
                    @(negedge clock);
                    w++;
                end
                chk($sformatf("rsp_word%0d", i), rsp_data, ref_mem[((RD_BASE / 4) + i) % 256]);
                repeat (stall) @(negedge clock);
                rsp_ready = 1'b1;
                @(negedge clock);
                rsp_ready = 1'b0;
            end
`endif
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("busy_done", busy, 0);
        chk("timeout_flag", timeout, expect_to);
        if (!expect_to) chk("run_cycles", run_cycles, d + 1);
        chk("we_pulses", we_pulses, q_a.size());
        chk("start_pulses", start_pulses, 1);
        chk("oe_pulses", oe_pulses, expect_to ? 0 : EXP_RD);
        chk("rsp_words", rv_count, expect_to ? 0 : EXP_RD);
        chk("protocol_errs", start_wide + both_err + hold_err + rsp_hold_err + ch1_err + size_err, 0);
        foreach (q_a[i]) chk("mem_image", mem[q_a[i][9:2]], ref_mem[q_a[i][9:2]]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < 256; i++) begin
            mem[i] = i;
            ref_mem[i] = i;
        end
        clear_mon();
        repeat (3) @(negedge clock);
        chk("rst_outputs", {cmd_ready, start_port, busy, timeout, rsp_valid, S_we_ram, S_oe_ram}, 0);
        chk("rst_run_cycles", run_cycles, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_cmd_ready", cmd_ready, 1);

        // Stray DataRdy while idle must not create or complete any access.
        stray_rdy = 1'b1;
        repeat (3) @(negedge clock);
        stray_rdy = 1'b0;
        chk("stray_no_we", {S_we_ram, S_oe_ram, busy}, 0);

        // Directed vector: three words, done 100 cycles after start.
        wdelay = 1;
        q_a = '{10'h0, 10'h4, 10'h8};
        q_d = '{32'h11, 32'h22, 32'h33};
        run_vector(100, 1'b0);

        // Randomized vectors.
        for (int v = 0; v < 3; v++) begin
            int n = $urandom_range(1, 5);
            q_a.delete(); q_d.delete();
            for (int i = 0; i < n; i++) begin
                q_a.push_back(10'($urandom_range(0, 255) * 4));
                q_d.push_back($urandom);
            end
            wdelay = $urandom_range(0, 3);
            rdelay = $urandom_range(0, 3);
            run_vector((v == 0) ? 0 : $urandom_range(2, 60), 1'b0);
        end

        // Reset asserted while a write is held waiting for DataRdy.
        wdelay = 20;
        saved = ref_mem[8'h10];
        send_cmd(10'h40, $urandom, 1'b0);
        chk("we_before_rst", S_we_ram, 2'b01);
        reset = 1'b0;
        #1;
        chk("rst_async_we", {S_we_ram, S_oe_ram, busy, cmd_ready, start_port}, 0);
        chk("rst_async_bus", {S_addr_ram, S_data_ram_size}, 0);
        chk("rst_async_data", S_Wdata_ram[63:0], 0);
        ref_mem[8'h10] = saved;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_idle", {cmd_ready, busy}, 2'b10);
        chk("post_rst_mem", mem[8'h10], ref_mem[8'h10]);
        wdelay = 1;

        // Timeout: done never arrives.
        q_a = '{10'h3FC, 10'h100};
        q_d = '{32'hCAFE0001, 32'hCAFE0002};
        run_vector(0, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("timeout_cleared", timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
